// File: rtl/minimig_toccata_fifo_if.sv
// CPU-side Zorro II bus bundle for the Toccata sound core.
interface minimig_toccata_fifo_if;
   logic [23:1] address_in;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        rd;
   logic        hwr;
   logic        lwr;
   logic        sel_out;

   modport master (output address_in, data_in, rd, hwr, lwr, input data_out, sel_out);
   modport slave  (input address_in, data_in, rd, hwr, lwr, output data_out, sel_out);
endinterface

// File: rtl/minimig_toccata_fifo.sv
// Toccata sound core: Zorro II register decode, PCM FIFO, rate timer, frame pop FSM and INT6.
// Optional MINIMIG_TOCCATA_MONO_EN: one mono word per frame, copied to both channels.
module minimig_toccata_fifo #(
   parameter int unsigned FIFO_AW  = 9,
   parameter logic [11:0] RATE_RST = 12'd160
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk7_en,
   minimig_toccata_fifo_if.slave bus,
   input  logic [7:0]            base_addr,
   input  logic                  configured,
   input  logic                  shutup,
   output logic                  int6,
   output logic [15:0]           left,
   output logic [15:0]           right,
   output logic                  sample_stb
);

   localparam int unsigned LW    = FIFO_AW + 1;
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_HALF  = LW'(DEPTH / 2);
   localparam logic [LW-1:0] LVL_HALF1 = LW'(DEPTH / 2 + 1);
`ifdef MINIMIG_TOCCATA_MONO_EN
   localparam logic [LW-1:0] MIN_LVL = LW'(1);
`else
   localparam logic [LW-1:0] MIN_LVL = LW'(2);
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, POPL = 2'd1, POPR = 2'd2, STB = 2'd3} state_t;

   state_t               state, state_nxt;
   logic                 play_en, irq_en, clr_pend, irq_pend, ovr, und;
   logic [11:0]          rate, cnt;
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]        level, level_nxt;
   logic [15:0]          mem [DEPTH];
   logic [15:0]          head;
   logic [2:0]           offs;
   logic                 wr, wr_ctrl, wr_rate, wr_data, wr_iack;
   logic                 full, empty, half, tick;
   logic                 pop_l, pop_r, und_set, push, pop, irq_set;
   logic                 unused_addr;

   // Window decode; offset bits above 3 alias into the 16-byte register block.
   assign bus.sel_out = configured & ~shutup & (bus.address_in[23:16] == base_addr);
   assign offs        = bus.address_in[3:1];
   assign unused_addr = ^bus.address_in[15:4];
   assign wr          = clk7_en & bus.sel_out & (bus.hwr | bus.lwr);
   assign wr_ctrl     = wr & (offs == 3'd0);
   assign wr_rate     = wr & (offs == 3'd1);
   assign wr_data     = wr & (offs == 3'd2);
   assign wr_iack     = wr & (offs == 3'd3);

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);
   assign half  = (level <= LVL_HALF);
   assign tick  = play_en & clk7_en & (cnt == 12'd0);
   assign head  = mem[rd_ptr];

   assign push      = wr_data & ~full;
   assign pop       = (pop_l | pop_r) & ~empty;
   assign level_nxt = level + LW'(push) - LW'(pop);
   assign irq_set   = play_en & ~clr_pend & (level == LVL_HALF1) & (level_nxt == LVL_HALF);
   assign int6      = irq_pend & irq_en;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Frame sequencer: a frame is only started when a whole frame is buffered.
   always_comb begin
      state_nxt = state;
      pop_l     = 1'b0;
      pop_r     = 1'b0;
      und_set   = 1'b0;
      case (state)
         IDLE: begin
            if (tick) begin
               if (level >= MIN_LVL) state_nxt = POPL;
               else                  und_set   = 1'b1;
            end
         end
         POPL: begin
            pop_l = 1'b1;
`ifdef MINIMIG_TOCCATA_MONO_EN
            state_nxt = STB;
`else
            state_nxt = POPR;
`endif
         end
         POPR: begin
            pop_r     = 1'b1;
            state_nxt = STB;
         end
         STB:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!play_en) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         play_en    <= 1'b0;
         irq_en     <= 1'b0;
         clr_pend   <= 1'b0;
         irq_pend   <= 1'b0;
         ovr        <= 1'b0;
         und        <= 1'b0;
         rate       <= RATE_RST;
         cnt        <= RATE_RST;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         left       <= 16'h0000;
         right      <= 16'h0000;
         sample_stb <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            play_en <= bus.data_in[0];
            irq_en  <= bus.data_in[1];
         end
         clr_pend <= wr_ctrl & bus.data_in[2];
         if (wr_rate) rate <= bus.data_in[11:0];

         // Sample-period timer holds at the reload value while stopped.
         if (!play_en)     cnt <= rate;
         else if (clk7_en) cnt <= (cnt == 12'd0) ? rate : cnt - 12'd1;

         if (clr_pend) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovr    <= 1'b0;
            und    <= 1'b0;
         end else begin
            if (push)            wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)             rd_ptr <= rd_ptr + FIFO_AW'(1);
            level <= level_nxt;
            if (wr_data & full)  ovr <= 1'b1;
            if (und_set)         und <= 1'b1;
         end

         if (irq_set)      irq_pend <= 1'b1;
         else if (wr_iack) irq_pend <= 1'b0;

         if (pop_l) begin
            left <= head;
`ifdef MINIMIG_TOCCATA_MONO_EN
            right <= head;
`endif
         end
         if (pop_r) right <= head;
         sample_stb <= (state_nxt == STB);
      end
   end

   always_comb begin
      bus.data_out = 16'h0000;
      if (bus.rd & bus.sel_out) begin
         case (offs)
            3'd0:    bus.data_out = {8'h00, irq_pend, full, empty, half, und, ovr, irq_en, play_en};
            3'd1:    bus.data_out = {4'h0, rate};
            3'd4:    bus.data_out = 16'(level);
            default: bus.data_out = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_minimig_toccata_fifo.sv
// Directed self-checking bench for minimig_toccata_fifo (FIFO_AW=4, depth 16).
module tb_minimig_toccata_fifo;

   logic        clk = 1'b0;
   logic        reset, clk7_en, configured, shutup, int6, sample_stb;
   logic [7:0]  base_addr;
   logic [15:0] left, right;
   int          total = 0;
   int          bad = 0;

   minimig_toccata_fifo_if bus ();

   minimig_toccata_fifo #(.FIFO_AW(4)) dut (
      .clk(clk), .reset(reset), .clk7_en(clk7_en), .bus(bus),
      .base_addr(base_addr), .configured(configured), .shutup(shutup),
      .int6(int6), .left(left), .right(right), .sample_stb(sample_stb)
   );

   always #5 clk = ~clk;

   function automatic logic [23:1] reg_addr(input logic [3:0] off);
      return {base_addr, 15'(off >> 1)};
   endfunction

   task automatic bus_write(input logic [3:0] off, input logic [15:0] d);
      @(negedge clk);
      bus.address_in = reg_addr(off);
      bus.data_in    = d;
      bus.hwr        = 1'b1;
      bus.lwr        = 1'b1;
      @(negedge clk);
      bus.hwr = 1'b0;
      bus.lwr = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] off, output logic [15:0] d);
      @(negedge clk);
      bus.address_in = reg_addr(off);
      bus.rd         = 1'b1;
      #1 d = bus.data_out;
      bus.rd = 1'b0;
   endtask

   // Returns the number of falling edges until the strobe is seen, or -1 on timeout.
   task automatic wait_stb(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (sample_stb === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      reset = 1'b1; clk7_en = 1'b1; configured = 1'b0; shutup = 1'b0; base_addr = 8'hE9;
      bus.address_in = '0; bus.data_in = '0; bus.rd = 1'b0; bus.hwr = 1'b0; bus.lwr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++; if (int6 !== 1'b0) begin bad++; $display("FAIL reset_int6 got=%b exp=0", int6); end
      total++; if (left !== 16'h0 || right !== 16'h0) begin bad++; $display("FAIL reset_lr got=%h/%h exp=0000/0000", left, right); end
      total++; if (sample_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", sample_stb); end
      total++; if (bus.sel_out !== 1'b0) begin bad++; $display("FAIL reset_sel_unconfigured got=%b exp=0", bus.sel_out); end
      configured = 1'b1;
      bus_read(4'h0, d);
      // HALF is set whenever level <= depth/2, which includes empty.
      total++; if (d !== 16'h0030) begin bad++; $display("FAIL reset_ctrl got=%h exp=0030", d); end
      bus_read(4'h2, d);
      total++; if (d !== 16'h00A0) begin bad++; $display("FAIL reset_rate got=%h exp=00a0", d); end
      bus_read(4'h8, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_level got=%h exp=0000", d); end
   endtask

   task automatic test_decode();
      logic [15:0] d;
      bus_write(4'h0, 16'h0001);
      bus_read(4'h0, d);
      total++; if (d !== 16'h0031) begin bad++; $display("FAIL decode_ctrl got=%h exp=0031", d); end
      total++; if (bus.sel_out !== 1'b1) begin bad++; $display("FAIL decode_sel got=%b exp=1", bus.sel_out); end
      bus_write(4'h0, 16'h0000);
      shutup = 1'b1;
      @(negedge clk);
      bus.address_in = reg_addr(4'h2);
      bus.rd = 1'b1;
      #1;
      total++; if (bus.sel_out !== 1'b0) begin bad++; $display("FAIL decode_shutup_sel got=%b exp=0", bus.sel_out); end
      total++; if (bus.data_out !== 16'h0) begin bad++; $display("FAIL decode_shutup_data got=%h exp=0000", bus.data_out); end
      bus.rd = 1'b0;
      bus_write(4'h2, 16'h0005);
      shutup = 1'b0;
      @(negedge clk);
      bus.address_in = {8'hE8, 15'd1};
      bus.rd = 1'b1;
      #1;
      total++; if (bus.sel_out !== 1'b0 || bus.data_out !== 16'h0) begin
         bad++; $display("FAIL decode_other_base got sel=%b data=%h exp sel=0 data=0000", bus.sel_out, bus.data_out); end
      bus.rd = 1'b0;
      bus_read(4'h2, d);
      total++; if (d !== 16'h00A0) begin bad++; $display("FAIL decode_shutup_write_ignored got=%h exp=00a0", d); end
   endtask

   task automatic test_clk_enable();
      int  n;
      bit  seen;
      bus_write(4'h0, 16'h0004);
      bus_write(4'h2, 16'h0000);
      bus_write(4'h4, 16'hAAAA);
      bus_write(4'h4, 16'h5555);
      bus_write(4'h0, 16'h0001);
      clk7_en = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (sample_stb === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL clken_gated got strobe=%b exp=0", seen); end
      clk7_en = 1'b1;
      wait_stb(12, n);
      total++; if (n < 0) begin bad++; $display("FAIL clken_resume got=timeout exp=strobe"); end
`ifdef MINIMIG_TOCCATA_MONO_EN
      total++; if (left !== 16'hAAAA || right !== 16'hAAAA) begin bad++; $display("FAIL clken_lr got=%h/%h exp=aaaa/aaaa", left, right); end
`else
      total++; if (left !== 16'hAAAA || right !== 16'h5555) begin bad++; $display("FAIL clken_lr got=%h/%h exp=aaaa/5555", left, right); end
`endif
      @(negedge clk);
      total++; if (sample_stb !== 1'b0) begin bad++; $display("FAIL stb_width got=%b exp=0", sample_stb); end
      bus_write(4'h0, 16'h0000);
   endtask

`ifdef MINIMIG_TOCCATA_MONO_EN
   task automatic test_mono();
      logic [15:0] d;
      int          n;
      bus_write(4'h0, 16'h0004);
      bus_write(4'h2, 16'h0003);
      bus_write(4'h4, 16'h7FFF);
      bus_read(4'h8, d);
      total++; if (d !== 16'h0001) begin bad++; $display("FAIL mono_level_before got=%h exp=0001", d); end
      bus_write(4'h0, 16'h0001);
      wait_stb(40, n);
      // Counter 3->0 takes three edges, then tick, POPL, STB.
      total++; if (n !== 5) begin bad++; $display("FAIL mono_latency got=%0d exp=5", n); end
      total++; if (left !== 16'h7FFF || right !== 16'h7FFF) begin bad++; $display("FAIL mono_lr got=%h/%h exp=7fff/7fff", left, right); end
      bus_read(4'h8, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL mono_level_after got=%h exp=0000", d); end
      bus_write(4'h0, 16'h0000);
   endtask
`else
   task automatic test_playback();
      logic [15:0] d;
      int          n;
      bit          seen;
      bus_write(4'h0, 16'h0004);
      bus_write(4'h2, 16'h0003);
      bus_write(4'h4, 16'h1111);
      bus_write(4'h4, 16'h2222);
      bus_write(4'h4, 16'h3333);
      bus_write(4'h4, 16'h4444);
      bus_write(4'h0, 16'h0001);
      wait_stb(40, n);
      // Counter 3->0 takes three edges, then tick, POPL, POPR, STB.
      total++; if (n !== 6) begin bad++; $display("FAIL play_first_latency got=%0d exp=6", n); end
      total++; if (left !== 16'h1111 || right !== 16'h2222) begin bad++; $display("FAIL play_frame1 got=%h/%h exp=1111/2222", left, right); end
      wait_stb(40, n);
      total++; if (n !== 4) begin bad++; $display("FAIL play_period got=%0d exp=4", n); end
      total++; if (left !== 16'h3333 || right !== 16'h4444) begin bad++; $display("FAIL play_frame2 got=%h/%h exp=3333/4444", left, right); end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (sample_stb === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL play_underrun_stb got=%b exp=0", seen); end
      bus_read(4'h0, d);
      total++; if (d !== 16'h0039) begin bad++; $display("FAIL play_und_ctrl got=%h exp=0039", d); end
      total++; if (left !== 16'h3333 || right !== 16'h4444) begin bad++; $display("FAIL play_hold got=%h/%h exp=3333/4444", left, right); end
      bus_write(4'h0, 16'h0000);
   endtask

   task automatic test_overflow_irq();
      logic [15:0] d;
      int          n;
      bus_write(4'h0, 16'h0004);
      bus_write(4'h2, 16'h000F);
      for (int i = 1; i <= 17; i++) bus_write(4'h4, 16'h0100 + 16'(i));
      bus_read(4'h8, d);
      total++; if (d !== 16'h0010) begin bad++; $display("FAIL ovf_level got=%h exp=0010", d); end
      bus_read(4'h0, d);
      total++; if (d !== 16'h0044) begin bad++; $display("FAIL ovf_ctrl got=%h exp=0044", d); end
      bus_write(4'h0, 16'h0003);
      for (int f = 1; f <= 8; f++) begin
         wait_stb(60, n);
         total++; if (n < 0) begin bad++; $display("FAIL irq_frame%0d got=timeout exp=strobe", f); end
         if (f == 3) begin
            total++; if (int6 !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", int6); end
         end
         if (f == 4) begin
            total++; if (int6 !== 1'b1) begin bad++; $display("FAIL irq_at_level8 got=%b exp=1", int6); end
            bus_write(4'h6, 16'h0000);
            total++; if (int6 !== 1'b0) begin bad++; $display("FAIL irq_iack got=%b exp=0", int6); end
         end
      end
      total++; if (left !== 16'h010F || right !== 16'h0110) begin bad++; $display("FAIL ovf_last_frame got=%h/%h exp=010f/0110", left, right); end
      total++; if (int6 !== 1'b0) begin bad++; $display("FAIL irq_no_reassert got=%b exp=0", int6); end
      bus_read(4'h8, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL ovf_drained got=%h exp=0000", d); end
      bus_write(4'h0, 16'h0000);
   endtask

   // Leaves the core in the POPR state of the second frame for test_reset_mid_frame.
   task automatic test_push_pop_same();
      int n;
      bus_write(4'h0, 16'h0004);
      bus_write(4'h2, 16'h0003);
      for (int i = 1; i <= 4; i++) bus_write(4'h4, 16'h0A00 + 16'(i));
      bus_write(4'h0, 16'h0001);
      wait_stb(40, n);
      total++; if (n < 0) begin bad++; $display("FAIL pp_frame1 got=timeout exp=strobe"); end
      @(negedge clk);
      @(negedge clk);
      bus.address_in = reg_addr(4'h4);
      bus.data_in    = 16'h0A05;
      bus.hwr        = 1'b1;
      bus.lwr        = 1'b1;
      @(negedge clk);
      bus.hwr = 1'b0;
      bus.lwr = 1'b0;
      bus.address_in = reg_addr(4'h8);
      bus.rd = 1'b1;
      #1;
      total++; if (bus.data_out !== 16'h0002) begin bad++; $display("FAIL pp_level got=%h exp=0002", bus.data_out); end
      total++; if (left !== 16'h0A03) begin bad++; $display("FAIL pp_left got=%h exp=0a03", left); end
      bus.rd = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d;
      bit          seen;
      reset = 1'b1;
      @(negedge clk);
      total++; if (left !== 16'h0 || right !== 16'h0) begin bad++; $display("FAIL rst_mid_lr got=%h/%h exp=0000/0000", left, right); end
      reset = 1'b0;
      seen = (sample_stb === 1'b1);
      repeat (12) begin
         @(negedge clk);
         if (sample_stb === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_stb got=%b exp=0", seen); end
      bus_read(4'h8, d);
      total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_mid_level got=%h exp=0000", d); end
      bus_read(4'h2, d);
      total++; if (d !== 16'h00A0) begin bad++; $display("FAIL rst_mid_rate got=%h exp=00a0", d); end
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_clk_enable();
`ifdef MINIMIG_TOCCATA_MONO_EN
      test_mono();
`else
      test_playback();
      test_overflow_irq();
      test_push_pop_same();
      test_reset_mid_frame();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
